sdcard_cmd_engine: RTL and testbench

Serial CMD-line engine of the SD card controller. It sits between the APB register block and the `sdcard_cmd_io` pad. It accepts a command (index, argument, response type) over a valid/ready handshake and builds the 48-bit frame with CRC7. It shifts the frame out on the SD clock, captures and checks the card response, then reports one completion strobe with response data and error flags.

---
 rtl/sdcard_pkg.sv | 26 ++
 rtl/sdcard_crc7.sv | 31 +++
 rtl/sdcard_cmd_engine.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_sdcard_cmd_engine.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdcard_pkg.sv
// Shared types and constants for the SD card CMD-line logic.
//   resp_type_e : response type requested with a command
//   cmd_state_e : CMD engine FSM states
//   frame lengths and the CRC7 generator polynomial
package sdcard_pkg;

    typedef enum logic [1:0] {
        RESP_NONE        = 2'd0,
        RESP_SHORT       = 2'd1,
        RESP_SHORT_NOCRC = 2'd2,
        RESP_LONG        = 2'd3
    } resp_type_e;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        RECV,
        TURN
    } cmd_state_e;

    localparam int         CMD_FRAME_LEN  = 48;
    localparam int         LONG_FRAME_LEN = 136;
    localparam logic [6:0] CRC7_POLY      = 7'h09;

endpackage

// File: rtl/sdcard_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first, initial value 0.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : return the remainder to 0
//   en_i           : fold bit_i into the remainder this cycle
//   bit_i          : data bit
//   crc_o          : current remainder
module sdcard_crc7
    import sdcard_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic fb;

    assign fb = bit_i ^ crc_o[6];

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            crc_o <= '0;
        end else if (en_i) begin
            crc_o <= {crc_o[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sdcard_cmd_engine.sv
// Serial CMD-line engine: accepts a command, sends the 48-bit frame with
// CRC7, receives and checks the card response, reports one done strobe.
// Ports:
//   clk_i, reset_i                 : clock, synchronous active-high reset
//   sd_tick_i                      : one strobe per SD clock period
//   cmd_valid_i/cmd_ready_o        : command handshake
//   cmd_index_i, cmd_arg_i, resp_type_i : command fields
//   cmd_o, cmd_oe_o, cmd_i         : CMD pad drive, enable, sample
//   done_o                         : one-cycle completion strobe
//   resp_index_o, resp_o           : received response fields
//   timeout_err_o, crc_err_o, index_err_o, frame_err_o : completion status
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | ready for a command
// SEND      | driving frame bits 47..0, one per tick
// WAIT_RESP | line released, looking for the response start bit
// RECV      | shifting in the remaining response bits
// TURN      | NCC idle ticks before accepting the next command
module sdcard_cmd_engine
    import sdcard_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64,
    parameter int NCC_TICKS    = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         sd_tick_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   resp_type_i,
    output logic         cmd_o,
    output logic         cmd_oe_o,
    input  logic         cmd_i,
    output logic         done_o,
    output logic [5:0]   resp_index_o,
    output logic [127:0] resp_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         index_err_o,
    output logic         frame_err_o
);

    cmd_state_e   state_q, state_d;
    resp_type_e   type_q, type_d;
    logic [5:0]   idx_q, idx_d;
    logic [39:0]  tx_sr_q, tx_sr_d;
    logic [5:0]   bit_cnt_q, bit_cnt_d;
    logic         tx_last_q, tx_last_d;
    logic [6:0]   wait_cnt_q, wait_cnt_d;
    logic [7:0]   rx_cnt_q, rx_cnt_d;
    logic [133:0] rx_sr_q, rx_sr_d;
    logic [7:0]   ncc_cnt_q, ncc_cnt_d;

    logic         ready_d, cmd_d, oe_d, done_d;
    logic [5:0]   resp_index_d;
    logic [127:0] resp_d;
    logic         tmo_d, crc_err_d, idx_err_d, frm_err_d;

    logic         crc_clr, tx_crc_en, rx_crc_en;
    logic [6:0]   tx_crc, rx_crc;
    logic [2:0]   crc_sel;
    logic [134:0] rx_frame;

    // Frame bits 7..1 map onto remainder bits 6..0.
    assign crc_sel  = bit_cnt_q[2:0] - 3'd1;
    // Complete response as of the tick that samples its last bit.
    assign rx_frame = {rx_sr_q, cmd_i};

    sdcard_crc7 u_tx_crc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (crc_clr),
        .en_i    (tx_crc_en),
        .bit_i   (tx_sr_q[39]),
        .crc_o   (tx_crc)
    );

    sdcard_crc7 u_rx_crc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (crc_clr),
        .en_i    (rx_crc_en),
        .bit_i   (cmd_i),
        .crc_o   (rx_crc)
    );

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        idx_d        = idx_q;
        tx_sr_d      = tx_sr_q;
        bit_cnt_d    = bit_cnt_q;
        tx_last_d    = tx_last_q;
        wait_cnt_d   = wait_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        rx_sr_d      = rx_sr_q;
        ncc_cnt_d    = ncc_cnt_q;
        ready_d      = 1'b0;
        cmd_d        = 1'b1;
        oe_d         = 1'b0;
        done_d       = 1'b0;
        resp_index_d = resp_index_o;
        resp_d       = resp_o;
        tmo_d        = timeout_err_o;
        crc_err_d    = crc_err_o;
        idx_err_d    = index_err_o;
        frm_err_d    = frame_err_o;
        crc_clr      = 1'b0;
        tx_crc_en    = 1'b0;
        rx_crc_en    = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_o) begin
                    ready_d   = 1'b0;
                    oe_d      = 1'b1;
                    state_d   = SEND;
                    type_d    = resp_type_e'(resp_type_i);
                    idx_d     = cmd_index_i;
                    tx_sr_d   = {2'b01, cmd_index_i, cmd_arg_i};
                    bit_cnt_d = 6'(CMD_FRAME_LEN - 1);
                    tx_last_d = 1'b0;
                    crc_clr   = 1'b1;
                    tmo_d     = 1'b0;
                    crc_err_d = 1'b0;
                    idx_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end

            SEND: begin
                oe_d  = 1'b1;
                cmd_d = cmd_o;
                if (sd_tick_i) begin
                    if (tx_last_q) begin
                        // Bit 0 has been on the line for a full SD period.
                        oe_d  = 1'b0;
                        cmd_d = 1'b1;
                        if (type_q == RESP_NONE) begin
                            done_d    = 1'b1;
                            ncc_cnt_d = 8'(NCC_TICKS);
                            state_d   = TURN;
                        end else begin
                            wait_cnt_d = 7'd1;
                            state_d    = WAIT_RESP;
                        end
                    end else begin
                        if (bit_cnt_q >= 6'd8) begin
                            cmd_d     = tx_sr_q[39];
                            tx_sr_d   = {tx_sr_q[38:0], 1'b0};
                            tx_crc_en = 1'b1;
                        end else if (bit_cnt_q != 6'd0) begin
                            cmd_d = tx_crc[crc_sel];
                        end else begin
                            cmd_d = 1'b1;
                        end
                        if (bit_cnt_q == 6'd0) begin
                            tx_last_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 6'd1;
                        end
                    end
                end
            end

            WAIT_RESP: begin
                if (sd_tick_i) begin
                    if (!cmd_i) begin
                        // The start bit is frame bit 47 (or 135) and is part of
                        // the CRC span only for short responses.
                        rx_sr_d   = {rx_sr_q[132:0], cmd_i};
                        rx_crc_en = (type_q != RESP_LONG);
                        rx_cnt_d  = (type_q == RESP_LONG) ? 8'(LONG_FRAME_LEN - 2)
                                                          : 8'(CMD_FRAME_LEN - 2);
                        state_d   = RECV;
                    end else if (wait_cnt_q == 7'(RESP_TIMEOUT)) begin
                        tmo_d     = 1'b1;
                        done_d    = 1'b1;
                        ncc_cnt_d = 8'(NCC_TICKS);
                        state_d   = TURN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 7'd1;
                    end
                end
            end

            RECV: begin
                if (sd_tick_i) begin
                    rx_sr_d = {rx_sr_q[132:0], cmd_i};
                    if (type_q == RESP_LONG) begin
                        rx_crc_en = (rx_cnt_q >= 8'd8) && (rx_cnt_q <= 8'd127);
                    end else begin
                        rx_crc_en = (rx_cnt_q >= 8'd8);
                    end
                    if (rx_cnt_q == 8'd0) begin
                        done_d    = 1'b1;
                        ncc_cnt_d = 8'(NCC_TICKS);
                        state_d   = TURN;
                        crc_err_d = (rx_frame[7:1] != rx_crc);
                        if (type_q == RESP_LONG) begin
                            resp_d       = rx_frame[127:0];
                            resp_index_d = '0;
                            frm_err_d    = rx_frame[134] || (rx_frame[133:128] != 6'h3F)
                                           || !rx_frame[0];
                        end else begin
                            resp_d       = {96'b0, rx_frame[39:8]};
                            resp_index_d = rx_frame[45:40];
                            frm_err_d    = rx_frame[46] || !rx_frame[0];
                            if (type_q == RESP_SHORT) begin
                                idx_err_d = (rx_frame[45:40] != idx_q);
                            end else begin
                                crc_err_d = 1'b0;
                            end
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q - 8'd1;
                    end
                end
            end

            TURN: begin
                if (sd_tick_i) begin
                    if (ncc_cnt_q <= 8'd1) begin
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ncc_cnt_d = ncc_cnt_q - 8'd1;
                    end
                end
            end

            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            type_q        <= RESP_NONE;
            idx_q         <= '0;
            tx_sr_q       <= '0;
            bit_cnt_q     <= '0;
            tx_last_q     <= 1'b0;
            wait_cnt_q    <= '0;
            rx_cnt_q      <= '0;
            rx_sr_q       <= '0;
            ncc_cnt_q     <= '0;
            cmd_ready_o   <= 1'b1;
            cmd_o         <= 1'b1;
            cmd_oe_o      <= 1'b0;
            done_o        <= 1'b0;
            resp_index_o  <= '0;
            resp_o        <= '0;
            timeout_err_o <= 1'b0;
            crc_err_o     <= 1'b0;
            index_err_o   <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            idx_q         <= idx_d;
            tx_sr_q       <= tx_sr_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_last_q     <= tx_last_d;
            wait_cnt_q    <= wait_cnt_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_sr_q       <= rx_sr_d;
            ncc_cnt_q     <= ncc_cnt_d;
            cmd_ready_o   <= ready_d;
            cmd_o         <= cmd_d;
            cmd_oe_o      <= oe_d;
            done_o        <= done_d;
            resp_index_o  <= resp_index_d;
            resp_o        <= resp_d;
            timeout_err_o <= tmo_d;
            crc_err_o     <= crc_err_d;
            index_err_o   <= idx_err_d;
            frame_err_o   <= frm_err_d;
        end
    end

endmodule

// File: tb/tb_sdcard_cmd_engine.sv
// Bench for sdcard_cmd_engine: table of commands with card replies, a
// scoreboard of expected completions checked on done_o, plus reset sequences.
module tb_sdcard_cmd_engine;
    import sdcard_pkg::*;

    localparam int RESP_TIMEOUT = 64;
    localparam int NCC_TICKS    = 8;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         sd_tick_i;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [5:0]   cmd_index_i;
    logic [31:0]  cmd_arg_i;
    logic [1:0]   resp_type_i;
    logic         cmd_o;
    logic         cmd_oe_o;
    logic         cmd_i;
    logic         done_o;
    logic [5:0]   resp_index_o;
    logic [127:0] resp_o;
    logic         timeout_err_o, crc_err_o, index_err_o, frame_err_o;

    always #5 clk_i = ~clk_i;

    sdcard_cmd_engine #(
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .NCC_TICKS    (NCC_TICKS)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .sd_tick_i     (sd_tick_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_index_i   (cmd_index_i),
        .cmd_arg_i     (cmd_arg_i),
        .resp_type_i   (resp_type_i),
        .cmd_o         (cmd_o),
        .cmd_oe_o      (cmd_oe_o),
        .cmd_i         (cmd_i),
        .done_o        (done_o),
        .resp_index_o  (resp_index_o),
        .resp_o        (resp_o),
        .timeout_err_o (timeout_err_o),
        .crc_err_o     (crc_err_o),
        .index_err_o   (index_err_o),
        .frame_err_o   (frame_err_o)
    );

    typedef struct {
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   rtype;
        logic [47:0]  tx_frame;
        int           delay;
        int           reply_len;
        logic [135:0] reply;
        logic         chk_resp;
        logic [127:0] resp;
        logic [5:0]   ridx;
        logic [3:0]   flags;      // {timeout, crc, index, frame}
        logic         busy_valid; // keep cmd_valid_i high while busy
    } vec_t;

    typedef struct {
        logic         chk_resp;
        logic [127:0] resp;
        logic [5:0]   ridx;
        logic [3:0]   flags;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] d, input int hi, input int lo);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = hi; i >= lo; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] build_tx(input logic [5:0] idx, input logic [31:0] arg);
        logic [47:0] f;
        f       = {2'b01, idx, arg, 8'h01};
        f[7:1]  = crc7({88'b0, f}, 47, 8);
        return f;
    endfunction

    function automatic logic [135:0] short_reply(input logic [5:0] idx, input logic [31:0] arg);
        logic [47:0] f;
        f      = {2'b00, idx, arg, 8'h01};
        f[7:1] = crc7({88'b0, f}, 47, 8);
        return {88'b0, f};
    endfunction

    function automatic logic [135:0] long_reply(input logic [7:0] hdr, input logic [119:0] cid);
        logic [135:0] r;
        r      = {hdr, cid, 8'h01};
        r[7:1] = crc7(r, 127, 8);
        return r;
    endfunction

    function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                                input int d, input int len, input logic [135:0] reply,
                                input logic chk_r, input logic [127:0] resp, input logic [5:0] ridx,
                                input logic [3:0] flags, input logic bv);
        vec_t v;
        v.idx = idx; v.arg = arg; v.rtype = rt; v.tx_frame = build_tx(idx, arg);
        v.delay = d; v.reply_len = len; v.reply = reply; v.chk_resp = chk_r;
        v.resp = resp; v.ridx = ridx; v.flags = flags; v.busy_valid = bv;
        return v;
    endfunction

    // Completion scoreboard.
    always @(negedge clk_i) begin
        if (done_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=1 expected=0");
            end else begin
                mon_e = sb.pop_front();
                chk("done_flags", {timeout_err_o, crc_err_o, index_err_o, frame_err_o}, mon_e.flags);
                if (mon_e.chk_resp) begin
                    chk("done_resp", resp_o, mon_e.resp);
                    chk("done_ridx", resp_index_o, mon_e.ridx);
                end
            end
        end
    end

    // One SD tick after an idle system cycle; returns outputs seen after the tick edge.
    task automatic do_tick(input logic line, output logic o_cmd, output logic o_oe,
                           output logic o_done, output logic o_ready);
        @(negedge clk_i);
        cmd_i     = line;
        sd_tick_i = 1'b1;
        @(negedge clk_i);
        sd_tick_i = 1'b0;
        o_cmd     = cmd_o;
        o_oe      = cmd_oe_o;
        o_done    = done_o;
        o_ready   = cmd_ready_o;
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!cmd_ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        logic [47:0] tx_got;
        logic        oc, ooe, od, ordy, line;
        int          done_at, ready_at, n_done, oe_bad, start_t, exp_done;
        exp_t        e;
        tx_got = '0; done_at = -1; ready_at = -1; n_done = 0; oe_bad = 0;
        wait_ready();
        chk({tag, "_ready_idle"}, cmd_ready_o, 1);
        e.chk_resp = v.chk_resp; e.resp = v.resp; e.ridx = v.ridx; e.flags = v.flags;
        sb.push_back(e);
        cmd_index_i = v.idx;
        cmd_arg_i   = v.arg;
        resp_type_i = v.rtype;
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        chk({tag, "_ready_drop"}, cmd_ready_o, 0);
        if (v.busy_valid) begin
            cmd_index_i = ~v.idx;
            cmd_arg_i   = ~v.arg;
            resp_type_i = ~v.rtype;
        end else begin
            cmd_valid_i = 1'b0;
        end
        start_t = 50 + v.delay;
        for (int t = 1; t <= 400 && ready_at < 0; t++) begin
            line = 1'b1;
            if (v.reply_len > 0 && t >= start_t && t < start_t + v.reply_len)
                line = v.reply[v.reply_len - 1 - (t - start_t)];
            do_tick(line, oc, ooe, od, ordy);
            if (t <= 48) begin
                tx_got[48 - t] = oc;
                if (!ooe) oe_bad++;
            end else if (ooe) begin
                oe_bad++;
            end
            if (od) begin
                n_done++;
                if (done_at < 0) done_at = t;
            end
            if (ordy) begin
                ready_at    = t;
                cmd_valid_i = 1'b0;
            end
        end
        cmd_valid_i = 1'b0;
        cmd_i       = 1'b1;
        if (v.rtype == 2'd0)       exp_done = 49;
        else if (v.reply_len == 0) exp_done = 49 + RESP_TIMEOUT;
        else                       exp_done = 49 + v.delay + v.reply_len;
        chk({tag, "_tx_frame"}, tx_got, v.tx_frame);
        chk({tag, "_oe_window"}, oe_bad, 0);
        chk({tag, "_done_count"}, n_done, 1);
        chk({tag, "_done_tick"}, done_at, exp_done);
        chk({tag, "_ready_tick"}, ready_at, done_at + NCC_TICKS);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, cmd_ready_o, 1);
        chk({tag, "_cmd"}, cmd_o, 1);
        chk({tag, "_oe"}, cmd_oe_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_resp"}, resp_o, 0);
        chk({tag, "_ridx"}, resp_index_o, 0);
        chk({tag, "_flags"}, {timeout_err_o, crc_err_o, index_err_o, frame_err_o}, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [135:0] r;
        logic [119:0] cid;
        logic         oc, ooe, od, ordy;
        int           oe_seen;

        cid = 120'h03_5344_5344_3332_4780_1234_5678_0091;

        vecs[0] = mk(6'd0, 32'h0, 2'd0, 0, 0, '0, 1'b0, '0, '0, 4'b0000, 1'b0);
        vecs[0].tx_frame = 48'h40_0000_0000_95;
        vecs[1] = mk(6'd8, 32'h1AA, 2'd1, 5, 48, {88'b0, 48'h08_0000_01AA_13},
                     1'b1, 128'h1AA, 6'd8, 4'b0000, 1'b1);
        vecs[1].tx_frame = 48'h48_0000_01AA_87;
        vecs[2] = mk(6'd8, 32'h1AA, 2'd1, 5, 48, {88'b0, 48'h08_0000_01AB_13},
                     1'b1, 128'h1AB, 6'd8, 4'b0100, 1'b0);
        vecs[3] = mk(6'd8, 32'h1AA, 2'd1, 3, 48, short_reply(6'd9, 32'h1AA),
                     1'b1, 128'h1AA, 6'd9, 4'b0010, 1'b0);
        vecs[4] = mk(6'd8, 32'h1AA, 2'd1, 0, 48, {88'b0, 48'h48_0000_01AA_13},
                     1'b1, 128'h1AA, 6'd8, 4'b0101, 1'b0);
        vecs[5] = mk(6'd8, 32'h1AA, 2'd1, 0, 0, '0, 1'b0, '0, '0, 4'b1000, 1'b0);
        vecs[6] = mk(6'd41, 32'h40FF_8000, 2'd2, 2, 48, {88'b0, 48'h3F_80FF_8000_FF},
                     1'b1, 128'h80FF_8000, 6'h3F, 4'b0000, 1'b1);
        r = long_reply(8'h3F, cid);
        vecs[7] = mk(6'd2, 32'h0, 2'd3, 1, 136, r, 1'b1, r[127:0], 6'd0, 4'b0000, 1'b0);
        r = long_reply(8'h3E, cid);
        vecs[8] = mk(6'd2, 32'h0, 2'd3, 4, 136, r, 1'b1, r[127:0], 6'd0, 4'b0001, 1'b0);
        vecs[9] = mk(6'd8, 32'hCAFE_0001, 2'd1, RESP_TIMEOUT - 1, 48, short_reply(6'd8, 32'hCAFE_0001),
                     1'b1, 128'hCAFE_0001, 6'd8, 4'b0000, 1'b0);

        reset_i = 1'b1; sd_tick_i = 1'b0; cmd_valid_i = 1'b0; cmd_i = 1'b1;
        cmd_index_i = '0; cmd_arg_i = '0; resp_type_i = '0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk_reset_values("por");

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort in the middle of SEND: no completion, reset values next cycle.
        wait_ready();
        cmd_index_i = 6'd8; cmd_arg_i = 32'h1AA; resp_type_i = 2'd1; cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        for (int t = 0; t < 10; t++) do_tick(1'b1, oc, ooe, od, ordy);
        chk("midsend_oe", cmd_oe_o, 1);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        chk_reset_values("midsend_rst");
        oe_seen = 0;
        for (int t = 0; t < 60; t++) begin
            do_tick(1'b1, oc, ooe, od, ordy);
            if (ooe || !oc || od) oe_seen++;
        end
        chk("midsend_quiet", oe_seen, 0);

        run_cmd(vecs[0], "after_rst0");
        run_cmd(vecs[1], "after_rst1");

        repeat (5) @(negedge clk_i);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
